// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths and zero constants for the rename register file.
package regfile_pkg;
   localparam int REG_WIDTH  = 5;
   localparam int DATA_WIDTH = 32;
   localparam int ROB_WIDTH  = 4;
   localparam int REG_NUM    = 32;
   localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
   localparam logic [ROB_WIDTH-1:0]  ZERO_ROB  = '0;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one operand query with same-cycle commit forwarding and rename masking.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_WIDTH,
   parameter int ROB_W  = ROB_WIDTH
) (
   input  logic                 rdy_in,
   input  logic                 commit_enable,
   input  logic [REG_WIDTH-1:0] commit_des,
   input  logic [DATA_W-1:0]    commit_value,
   input  logic [ROB_W-1:0]     commit_reorder,
   input  logic [REG_WIDTH-1:0] req,
   input  logic [DATA_W-1:0]    reg_value,
   input  logic                 reg_busy,
   input  logic [ROB_W-1:0]     reg_tag,
   output logic [DATA_W-1:0]    value,
   output logic [ROB_W-1:0]     rename,
   output logic                 if_rename
);
   logic nonzero, fwd;
   always_comb begin
      nonzero   = req != '0;
      fwd       = rdy_in & commit_enable & (commit_des == req) & nonzero;
      value     = !nonzero ? '0 : fwd ? commit_value : reg_value;
      // a committing producer whose tag still owns the register releases it this cycle
      if_rename = nonzero & reg_busy & ~(fwd & (reg_tag == commit_reorder));
      rename    = if_rename ? reg_tag : '0;
   end
endmodule

// File: rtl/regfile.sv
// regfile: architectural registers with per-register ROB rename tags,
// commit retirement, flush of all tags and two forwarding read ports.
module regfile
   import regfile_pkg::*;
#(
   parameter int REG_NUM = regfile_pkg::REG_NUM,
   parameter int DATA_W  = DATA_WIDTH,
   parameter int ROB_W   = ROB_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic [REG_WIDTH-1:0] rs1_request,
   input  logic [REG_WIDTH-1:0] rs2_request,
   output logic [DATA_W-1:0]    rs1_value,
   output logic [DATA_W-1:0]    rs2_value,
   output logic [ROB_W-1:0]     rs1_rename,
   output logic [ROB_W-1:0]     rs2_rename,
   output logic                 rs1_if_rename,
   output logic                 rs2_if_rename,
   input  logic                 rename_enable,
   input  logic [REG_WIDTH-1:0] rename_rd,
   input  logic [ROB_W-1:0]     rename_reorder,
   input  logic                 commit_enable,
   input  logic [REG_WIDTH-1:0] commit_des,
   input  logic [DATA_W-1:0]    commit_value,
   input  logic [ROB_W-1:0]     commit_reorder,
   input  logic                 flush_in
);
   logic [DATA_W-1:0]  value_q [REG_NUM];
   logic [DATA_W-1:0]  value_d [REG_NUM];
   logic [ROB_W-1:0]   tag_q   [REG_NUM];
   logic [ROB_W-1:0]   tag_d   [REG_NUM];
   logic [REG_NUM-1:0] busy_q, busy_d;
   logic               commit_hit, rename_hit;

   always_comb begin
      value_d    = value_q;
      busy_d     = busy_q;
      tag_d      = tag_q;
      commit_hit = rdy_in & commit_enable & (commit_des != '0);
      rename_hit = rdy_in & rename_enable & (rename_rd != '0) & ~flush_in;
      if (commit_hit) begin
         value_d[commit_des] = commit_value;
         if (busy_q[commit_des] && tag_q[commit_des] == commit_reorder) busy_d[commit_des] = 1'b0;
      end
      if (rdy_in && flush_in) begin
         busy_d = '0;
         for (int i = 0; i < REG_NUM; i++) tag_d[i] = '0;
      end
      // rename after commit so a same-register rename keeps the register busy
      if (rename_hit) begin
         busy_d[rename_rd] = 1'b1;
         tag_d[rename_rd]  = rename_reorder;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         value_q <= '{default: '0};
         busy_q  <= '0;
         tag_q   <= '{default: '0};
      end else begin
         value_q <= value_d;
         busy_q  <= busy_d;
         tag_q   <= tag_d;
      end
   end

   regfile_read_port #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_rs1 (
      .rdy_in        (rdy_in),
      .commit_enable (commit_enable),
      .commit_des    (commit_des),
      .commit_value  (commit_value),
      .commit_reorder(commit_reorder),
      .req           (rs1_request),
      .reg_value     (value_q[rs1_request]),
      .reg_busy      (busy_q[rs1_request]),
      .reg_tag       (tag_q[rs1_request]),
      .value         (rs1_value),
      .rename        (rs1_rename),
      .if_rename     (rs1_if_rename)
   );

   regfile_read_port #(.DATA_W(DATA_W), .ROB_W(ROB_W)) u_rs2 (
      .rdy_in        (rdy_in),
      .commit_enable (commit_enable),
      .commit_des    (commit_des),
      .commit_value  (commit_value),
      .commit_reorder(commit_reorder),
      .req           (rs2_request),
      .reg_value     (value_q[rs2_request]),
      .reg_busy      (busy_q[rs2_request]),
      .reg_tag       (tag_q[rs2_request]),
      .value         (rs2_value),
      .rename        (rs2_rename),
      .if_rename     (rs2_if_rename)
   );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed vector table, randomized traffic against a register-array model, async reset check.
module tb_regfile;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic [4:0]  rs1_request = '0, rs2_request = '0;
   logic [31:0] rs1_value, rs2_value;
   logic [3:0]  rs1_rename, rs2_rename;
   logic        rs1_if_rename, rs2_if_rename;
   logic        rename_enable = 1'b0;
   logic [4:0]  rename_rd = '0;
   logic [3:0]  rename_reorder = '0;
   logic        commit_enable = 1'b0;
   logic [4:0]  commit_des = '0;
   logic [31:0] commit_value = '0;
   logic [3:0]  commit_reorder = '0;
   logic        flush_in = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   regfile dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .rs1_request(rs1_request), .rs2_request(rs2_request),
      .rs1_value(rs1_value), .rs2_value(rs2_value),
      .rs1_rename(rs1_rename), .rs2_rename(rs2_rename),
      .rs1_if_rename(rs1_if_rename), .rs2_if_rename(rs2_if_rename),
      .rename_enable(rename_enable), .rename_rd(rename_rd), .rename_reorder(rename_reorder),
      .commit_enable(commit_enable), .commit_des(commit_des),
      .commit_value(commit_value), .commit_reorder(commit_reorder),
      .flush_in(flush_in)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic rdy; logic [4:0] rs1, rs2;
      logic ren; logic [4:0] rd; logic [3:0] rtag;
      logic cen; logic [4:0] cdes; logic [31:0] cval; logic [3:0] ctag;
      logic flush;
      logic [31:0] v1; logic i1; logic [3:0] t1;
      logic [31:0] v2; logic i2; logic [3:0] t2;
   } vec_t;

   // architectural model: committed values, outstanding-producer flag and its ROB index
   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [3:0]  m_tag  [32];

   function automatic vec_t mk(input logic rdy, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic ren, input logic [4:0] rd, input logic [3:0] rtag,
                               input logic cen, input logic [4:0] cdes, input logic [31:0] cval,
                               input logic [3:0] ctag, input logic flush,
                               input logic [31:0] v1, input logic i1, input logic [3:0] t1,
                               input logic [31:0] v2, input logic i2, input logic [3:0] t2);
      vec_t v;
      v.rdy = rdy; v.rs1 = rs1; v.rs2 = rs2; v.ren = ren; v.rd = rd; v.rtag = rtag;
      v.cen = cen; v.cdes = cdes; v.cval = cval; v.ctag = ctag; v.flush = flush;
      v.v1 = v1; v.i1 = i1; v.t1 = t1; v.v2 = v2; v.i2 = i2; v.t2 = t2;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic predict(input vec_t v, input logic [4:0] rs,
                          output logic [31:0] val, output logic ifr, output logic [3:0] tag);
      bit fwd;
      fwd = v.rdy && v.cen && v.cdes == rs && rs != 0;
      val = (rs == 0) ? 32'd0 : fwd ? v.cval : m_val[rs];
      ifr = rs != 0 && m_busy[rs] && !(fwd && m_tag[rs] == v.ctag);
      tag = ifr ? m_tag[rs] : 4'd0;
   endtask

   task automatic model_step(input vec_t v);
      if (!v.rdy) return;
      if (v.cen && v.cdes != 0) begin
         m_val[v.cdes] = v.cval;
         if (m_busy[v.cdes] && m_tag[v.cdes] == v.ctag) m_busy[v.cdes] = 1'b0;
      end
      if (v.flush) begin
         for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = 4'd0; end
      end else if (v.ren && v.rd != 0) begin
         m_busy[v.rd] = 1'b1;
         m_tag[v.rd]  = v.rtag;
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
   endtask

   // one clock: drive after the edge, compare mid-cycle, then advance the model
   task automatic apply(input vec_t v, input string nm);
      @(posedge clk_in);
      #1;
      rdy_in = v.rdy; rs1_request = v.rs1; rs2_request = v.rs2;
      rename_enable = v.ren; rename_rd = v.rd; rename_reorder = v.rtag;
      commit_enable = v.cen; commit_des = v.cdes; commit_value = v.cval; commit_reorder = v.ctag;
      flush_in = v.flush;
      #3;
      chk({nm, " rs1_value"}, rs1_value, v.v1);
      chk({nm, " rs1_if_rename"}, {31'd0, rs1_if_rename}, {31'd0, v.i1});
      chk({nm, " rs1_rename"}, {28'd0, rs1_rename}, {28'd0, v.t1});
      chk({nm, " rs2_value"}, rs2_value, v.v2);
      chk({nm, " rs2_if_rename"}, {31'd0, rs2_if_rename}, {31'd0, v.i2});
      chk({nm, " rs2_rename"}, {28'd0, rs2_rename}, {28'd0, v.t2});
      model_step(v);
   endtask

   task automatic apply_model(input vec_t v, input string nm);
      predict(v, v.rs1, v.v1, v.i1, v.t1);
      predict(v, v.rs2, v.v2, v.i2, v.t2);
      apply(v, nm);
   endtask

   vec_t tbl[28];

   initial begin
      vec_t v;
      model_reset();
      tbl[0]  = mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 0, 5, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 0, 3, 1, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
      tbl[4]  = mk(1, 3, 3, 0, 0, 0, 1, 3, 32'h1234, 7, 0, 32'h1234, 0, 0, 32'h1234, 0, 0);
      tbl[5]  = mk(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 32'h1234, 0, 0);
      tbl[6]  = mk(1, 4, 0, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, 4, 0, 1, 4, 9, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
      tbl[8]  = mk(1, 4, 4, 0, 0, 0, 1, 4, 32'h55, 2, 0, 32'h55, 1, 9, 32'h55, 1, 9);
      tbl[9]  = mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 1, 9, 0, 0, 0);
      tbl[10] = mk(1, 6, 6, 1, 6, 3, 1, 6, 32'hAA, 1, 0, 32'hAA, 0, 0, 32'hAA, 0, 0);
      tbl[11] = mk(1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAA, 1, 3, 0, 0, 0);
      tbl[12] = mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(1, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, 0, 0, 1, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(1, 0, 0, 1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(1, 0, 0, 1, 7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[17] = mk(1, 0, 0, 1, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[18] = mk(1, 8, 1, 1, 9, 10, 0, 0, 0, 0, 1, 0, 1, 8, 0, 1, 1);
      tbl[19] = mk(1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0, 0, 0);
      tbl[20] = mk(1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAA, 0, 0, 32'h1234, 0, 0);
      tbl[21] = mk(0, 2, 2, 1, 2, 5, 1, 2, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[22] = mk(1, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[23] = mk(1, 0, 0, 1, 10, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[24] = mk(1, 10, 0, 0, 0, 0, 1, 10, 32'h99, 11, 1, 32'h99, 0, 0, 0, 0, 0);
      tbl[25] = mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 0);
      tbl[26] = mk(1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[27] = mk(1, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h99, 0, 0);

      rs1_request = 5'd5;
      #2;
      chk("reset rs1_value", rs1_value, 32'd0);
      chk("reset rs1_if_rename", {31'd0, rs1_if_rename}, 32'd0);
      chk("reset rs1_rename", {28'd0, rs1_rename}, 32'd0);
      rst_in = 1'b1;

      for (int k = 0; k < 28; k++) apply(tbl[k], $sformatf("tbl%0d", k));

      for (int k = 0; k < 400; k++) begin
         v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         v.rdy   = $urandom_range(0, 9) != 0;
         v.rs1   = $urandom_range(0, 3) != 0 ? 5'($urandom_range(0, 7)) : 5'($urandom);
         v.rs2   = $urandom_range(0, 3) != 0 ? 5'($urandom_range(0, 7)) : 5'($urandom);
         v.ren   = $urandom_range(0, 1);
         v.rd    = 5'($urandom_range(0, 7));
         v.rtag  = 4'($urandom);
         v.cen   = $urandom_range(0, 1);
         v.cdes  = 5'($urandom_range(0, 7));
         v.cval  = $urandom;
         v.ctag  = $urandom_range(0, 1) != 0 ? m_tag[v.cdes] : 4'($urandom);
         v.flush = $urandom_range(0, 19) == 0;
         apply_model(v, $sformatf("rnd%0d", k));
      end

      v = mk(1, 0, 0, 1, 13, 13, 1, 12, 32'h3C, 0, 0, 0, 0, 0, 0, 0, 0);
      apply_model(v, "pre_reset");
      v = mk(1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply_model(v, "pre_reset_read");
      rst_in = 1'b0;
      #1;
      chk("async_reset rs1_value", rs1_value, 32'd0);
      chk("async_reset rs2_if_rename", {31'd0, rs2_if_rename}, 32'd0);
      chk("async_reset rs2_rename", {28'd0, rs2_rename}, 32'd0);
      model_reset();
      #1;
      rst_in = 1'b1;
      v = mk(1, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      apply_model(v, "post_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
